// File: rtl/sram_port_arbiter.sv
// Arbitrates instruction-fetch and data-memory ports onto one async 16-bit SRAM.
// Optional round-robin arbitration on contention is enabled by defining SRAM_ARB_RR_EN.
//
// state | meaning
// IDLE  | sample requests, grant one, latch operands
// RD    | read strobe phase (READ_WAIT cycles), DQ captured on last cycle
// WR_SU | write address/data setup, WE_N high
// WR_PW | write pulse, WE_N low (WRITE_WAIT cycles)
// WR_HD | write hold, WE_N high, address/data/CE_N still held
// DONE  | ack to owner, strobes released, no new grant
module sram_port_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [1:0]        mem_be,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_CE_N
);

    typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_PW, WR_HD, DONE} state_t;

    state_t            state, next_state;
    logic [7:0]        wait_cnt;
    logic              owner_mem, next_owner_mem;
    logic              grant_mem, grant_any, prio_mem;
    logic [1:0]        be_q, next_be;
    logic [DATA_W-1:0] wdata_q;
    logic              dq_oe;

    assign SRAM_DQ = dq_oe ? wdata_q : {DATA_W{1'bz}};

`ifdef SRAM_ARB_RR_EN
    logic rr_mem;

    // Pointer moves only when both ports actually competed, so the loser of a
    // contention is guaranteed to win the next one.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N)
            rr_mem <= 1'b1;
        else if (state == IDLE && if_req && mem_req)
            rr_mem <= ~grant_mem;
    end

    assign prio_mem = rr_mem;
`else
    assign prio_mem = 1'b1;
`endif

    assign grant_any = if_req | mem_req;
    assign grant_mem = mem_req & (~if_req | prio_mem);

    always_comb begin
        next_state     = state;
        next_owner_mem = owner_mem;
        next_be        = be_q;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    next_owner_mem = grant_mem;
                    next_be        = (grant_mem && mem_we) ? mem_be : 2'b11;
                    if (grant_mem && mem_we)
                        next_state = (mem_be == 2'b00) ? DONE : WR_SU;
                    else
                        next_state = RD;
                end
            end
            RD:      if (wait_cnt == 8'd0) next_state = DONE;
            WR_SU:   next_state = WR_PW;
            WR_PW:   if (wait_cnt == 8'd0) next_state = WR_HD;
            WR_HD:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state     <= IDLE;
            owner_mem <= 1'b0;
            wait_cnt  <= 8'd0;
            be_q      <= 2'b11;
            wdata_q   <= '0;
            dq_oe     <= 1'b0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
        end else begin
            state     <= next_state;
            owner_mem <= next_owner_mem;
            be_q      <= next_be;

            if (state == IDLE)
                wait_cnt <= 8'(READ_WAIT - 1);
            else if (state == WR_SU)
                wait_cnt <= 8'(WRITE_WAIT - 1);
            else if (wait_cnt != 8'd0)
                wait_cnt <= wait_cnt - 8'd1;

            // Zero-byte-enable writes complete without touching the SRAM pins.
            if (state == IDLE && grant_any && next_state != DONE) begin
                SRAM_ADDR <= grant_mem ? mem_addr : if_addr;
                wdata_q   <= mem_wdata;
            end

            if (state == RD && wait_cnt == 8'd0) begin
                if (owner_mem)
                    mem_rdata <= SRAM_DQ;
                else
                    if_rdata <= SRAM_DQ;
            end

            SRAM_CE_N <= !(next_state == RD || next_state == WR_SU ||
                           next_state == WR_PW || next_state == WR_HD);
            SRAM_OE_N <= !(next_state == RD);
            SRAM_WE_N <= !(next_state == WR_PW);
            dq_oe     <= (next_state == WR_SU || next_state == WR_PW || next_state == WR_HD);

            if (next_state == RD) begin
                SRAM_UB_N <= 1'b0;
                SRAM_LB_N <= 1'b0;
            end else if (next_state == WR_SU || next_state == WR_PW || next_state == WR_HD) begin
                SRAM_UB_N <= ~next_be[1];
                SRAM_LB_N <= ~next_be[0];
            end else begin
                SRAM_UB_N <= 1'b1;
                SRAM_LB_N <= 1'b1;
            end

            if_ack  <= (next_state == DONE) && !next_owner_mem;
            mem_ack <= (next_state == DONE) && next_owner_mem;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small behavioural SRAM model.
// Expected values are hand-computed for READ_WAIT=WRITE_WAIT=1.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [17:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ub_n, lb_n, ce_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.ADDR_W(18), .DATA_W(16), .READ_WAIT(1), .WRITE_WAIT(1)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be   (mem_be),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .SRAM_DQ  (sram_dq),
        .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n),
        .SRAM_OE_N(oe_n),
        .SRAM_UB_N(ub_n),
        .SRAM_LB_N(lb_n),
        .SRAM_CE_N(ce_n)
    );

    // SRAM model: 256 words aliased on the low address byte.
    logic [15:0] sram_mem [256];
    logic        model_drv;
    logic [15:0] model_rd;

    always_comb begin
        model_drv = !ce_n && !oe_n && we_n;
        model_rd  = sram_mem[sram_addr[7:0]];
    end

    assign sram_dq = model_drv ? model_rd : 16'hzzzz;

    always @(posedge clk) begin
        if (!rst_n) begin
            sram_mem[8'h10] <= 16'hBEEF;
            sram_mem[8'hFF] <= 16'hAAAA;
        end else if (!ce_n && !we_n) begin
            if (!lb_n) sram_mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
            if (!ub_n) sram_mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    // Waits (bounded) for either ack; cyc stays 0 on timeout.
    task automatic wait_ack(output int cyc, output logic got_if, output logic got_mem,
                            output int oe_low, output int we_low, output int ce_low);
        cyc = 0; got_if = 1'b0; got_mem = 1'b0; oe_low = 0; we_low = 0; ce_low = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (!oe_n) oe_low++;
            if (!we_n) we_low++;
            if (!ce_n) ce_low++;
            if (if_ack || mem_ack) begin
                cyc = n; got_if = if_ack; got_mem = mem_ack;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_be = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if ({we_n, oe_n, ub_n, lb_n, ce_n} !== 5'b11111) begin
            errors++; $display("FAIL reset_strobes: got %b expected 11111", {we_n, oe_n, ub_n, lb_n, ce_n});
        end
        checks++;
        if (dut.dq_oe !== 1'b0) begin
            errors++; $display("FAIL reset_dq_oe: got %b expected 0", dut.dq_oe);
        end
        checks++;
        if ({if_ack, mem_ack} !== 2'b00) begin
            errors++; $display("FAIL reset_acks: got %b expected 00", {if_ack, mem_ack});
        end
        checks++;
        if (sram_addr !== 18'h0) begin
            errors++; $display("FAIL reset_addr: got %h expected 00000", sram_addr);
        end
        checks++;
        if ({if_rdata, mem_rdata} !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", {if_rdata, mem_rdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read;
        int cyc, oe_low, we_low, ce_low;
        logic gi, gm;
        if_req = 1'b1; if_addr = 18'h00010;
        wait_ack(cyc, gi, gm, oe_low, we_low, ce_low);
        if_req = 1'b0;
        checks++;
        if (cyc !== 2) begin
            errors++; $display("FAIL rd_latency: got %0d expected 2", cyc);
        end
        checks++;
        if ({gi, gm} !== 2'b10) begin
            errors++; $display("FAIL rd_owner: got %b expected 10", {gi, gm});
        end
        checks++;
        if (oe_low !== 1) begin
            errors++; $display("FAIL rd_oe_width: got %0d expected 1", oe_low);
        end
        checks++;
        if (if_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL rd_data: got %h expected beef", if_rdata);
        end
        @(negedge clk);
        checks++;
        if (if_ack !== 1'b0 || if_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL rd_ack_pulse: got ack=%b data=%h expected 0 beef", if_ack, if_rdata);
        end
    endtask

    task automatic test_write;
        int cyc, ce_low, we_low, bad, oe_low;
        logic gi, gm;
        cyc = 0; ce_low = 0; we_low = 0; bad = 0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h3FFFF; mem_wdata = 16'h1234; mem_be = 2'b01;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (!ce_n) begin
                ce_low++;
                if (sram_addr !== 18'h3FFFF || sram_dq !== 16'h1234 || lb_n !== 1'b0 ||
                    ub_n !== 1'b1 || oe_n !== 1'b1) bad++;
            end
            if (!we_n) we_low++;
            if (mem_ack) begin cyc = n; break; end
        end
        mem_req = 1'b0; mem_we = 1'b0;
        checks++;
        if (cyc !== 4) begin
            errors++; $display("FAIL wr_latency: got %0d expected 4", cyc);
        end
        checks++;
        if (ce_low !== 3) begin
            errors++; $display("FAIL wr_ce_width: got %0d expected 3", ce_low);
        end
        checks++;
        if (we_low !== 1) begin
            errors++; $display("FAIL wr_we_width: got %0d expected 1", we_low);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL wr_bus_stable: got %0d bad cycles expected 0", bad);
        end
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 18'h3FFFF;
        wait_ack(cyc, gi, gm, oe_low, we_low, ce_low);
        mem_req = 1'b0;
        checks++;
        if (cyc !== 2 || {gi, gm} !== 2'b01) begin
            errors++; $display("FAIL wr_readback_ack: got cyc=%0d owner=%b expected 2 01", cyc, {gi, gm});
        end
        checks++;
        if (mem_rdata !== 16'hAA34) begin
            errors++; $display("FAIL wr_readback_data: got %h expected aa34", mem_rdata);
        end
        checks++;
        if (if_rdata !== 16'hBEEF) begin
            errors++; $display("FAIL wr_if_rdata_held: got %h expected beef", if_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_contention;
        int cyc, oe_low, we_low, ce_low;
        logic gi, gm;
        logic first_mem;
        for (int round = 0; round < 2; round++) begin
`ifdef SRAM_ARB_RR_EN
            first_mem = (round == 0);
`else
            first_mem = 1'b1;
`endif
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 18'h00010;
            if_req  = 1'b1; if_addr = 18'h3FFFF;
            wait_ack(cyc, gi, gm, oe_low, we_low, ce_low);
            if (gm) mem_req = 1'b0;
            if (gi) if_req = 1'b0;
            checks++;
            if (cyc !== 2 || {gi, gm} !== {~first_mem, first_mem}) begin
                errors++; $display("FAIL arb_first_r%0d: got cyc=%0d owner=%b expected 2 %b",
                                   round, cyc, {gi, gm}, {~first_mem, first_mem});
            end
            wait_ack(cyc, gi, gm, oe_low, we_low, ce_low);
            mem_req = 1'b0; if_req = 1'b0;
            checks++;
            if (cyc !== 3 || {gi, gm} !== {first_mem, ~first_mem}) begin
                errors++; $display("FAIL arb_second_r%0d: got cyc=%0d owner=%b expected 3 %b",
                                   round, cyc, {gi, gm}, {first_mem, ~first_mem});
            end
            checks++;
            if (mem_rdata !== 16'hBEEF || if_rdata !== 16'hAA34) begin
                errors++; $display("FAIL arb_data_r%0d: got mem=%h if=%h expected beef aa34",
                                   round, mem_rdata, if_rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_be_zero;
        int cyc, oe_low, we_low, ce_low;
        logic gi, gm;
        logic [17:0] exp_addr;
`ifdef SRAM_ARB_RR_EN
        exp_addr = 18'h00010;
`else
        exp_addr = 18'h3FFFF;
`endif
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00055; mem_wdata = 16'hFFFF; mem_be = 2'b00;
        wait_ack(cyc, gi, gm, oe_low, we_low, ce_low);
        mem_req = 1'b0; mem_we = 1'b0;
        checks++;
        if (cyc !== 1 || {gi, gm} !== 2'b01) begin
            errors++; $display("FAIL be0_ack: got cyc=%0d owner=%b expected 1 01", cyc, {gi, gm});
        end
        checks++;
        if (ce_low !== 0 || we_low !== 0) begin
            errors++; $display("FAIL be0_strobes: got ce=%0d we=%0d expected 0 0", ce_low, we_low);
        end
        checks++;
        if (sram_addr !== exp_addr) begin
            errors++; $display("FAIL be0_addr_hold: got %h expected %h", sram_addr, exp_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, oe_low, we_low, ce_low, n_pw;
        logic gi, gm;
        n_pw = 0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h00020; mem_wdata = 16'h5555; mem_be = 2'b11;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (!we_n) begin n_pw = n; break; end
        end
        checks++;
        if (n_pw !== 2) begin
            errors++; $display("FAIL rst_mid_pw_reach: got %0d expected 2", n_pw);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (we_n !== 1'b1 || ce_n !== 1'b1 || dut.dq_oe !== 1'b0) begin
            errors++; $display("FAIL rst_mid_strobes: got we=%b ce=%b oe=%b expected 1 1 0", we_n, ce_n, dut.dq_oe);
        end
        checks++;
        if ({if_ack, mem_ack} !== 2'b00 || {if_rdata, mem_rdata} !== 32'h0) begin
            errors++; $display("FAIL rst_mid_outputs: got ack=%b rdata=%h expected 00 0",
                               {if_ack, mem_ack}, {if_rdata, mem_rdata});
        end
        rst_n = 1'b1;
        wait_ack(cyc, gi, gm, oe_low, we_low, ce_low);
        mem_req = 1'b0; mem_we = 1'b0;
        checks++;
        if (cyc !== 4 || {gi, gm} !== 2'b01 || we_low !== 1) begin
            errors++; $display("FAIL rst_mid_retry: got cyc=%0d owner=%b we=%0d expected 4 01 1",
                               cyc, {gi, gm}, we_low);
        end
        @(negedge clk);
        mem_req = 1'b1; mem_addr = 18'h00020;
        wait_ack(cyc, gi, gm, oe_low, we_low, ce_low);
        mem_req = 1'b0;
        checks++;
        if (cyc !== 2 || mem_rdata !== 16'h5555) begin
            errors++; $display("FAIL rst_mid_readback: got cyc=%0d data=%h expected 2 5555", cyc, mem_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_be_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
